// File: rtl/shot_rising_ctrl_if.sv
// Signal bundle between the rising-shot controller and its surroundings.
// The master side is the controller; the slave side is player input, aliens and VGA.
interface shot_rising_ctrl_if;
    logic       fire;
    logic [2:0] playerCol;
    logic [5:0] alienY;
    logic [7:0] alienMask;
    logic       gameOver;
    logic       drawDone;
    logic       drawReq;
    logic       drawColour;
    logic [2:0] shotX;
    logic [5:0] shotY;
    logic       active;
    logic       hit;
    logic [2:0] hitCol;
    logic       miss;

    modport master (
        input  fire, playerCol, alienY, alienMask, gameOver, drawDone,
        output drawReq, drawColour, shotX, shotY, active, hit, hitCol, miss
    );

    modport slave (
        output fire, playerCol, alienY, alienMask, gameOver, drawDone,
        input  drawReq, drawColour, shotX, shotY, active, hit, hitCol, miss
    );
endinterface

// File: rtl/shot_rising_ctrl.sv
// Player shot controller: launches from the player column, steps up one row per period,
// draws/erases through the VGA request/done handshake and reports hit or miss.
module shot_rising_ctrl #(
    parameter int unsigned CLOCK_FREQUENCY = 50000000,
    parameter int unsigned STEP_CYCLES     = CLOCK_FREQUENCY / 3,
    parameter logic [5:0]  Y_START         = 6'd58
) (
    input logic                clk,
    input logic                Reset,
    shot_rising_ctrl_if.master bus_io
);

    typedef enum logic [2:0] {
        StIdle,
        StDraw,
        StWait,
        StErase,
        StMove,
        StCheck
    } state_e;

    state_e      state_q;
    logic [31:0] cnt_q;
    logic        draw_req_q;
    logic        draw_colour_q;
    logic [2:0]  shot_x_q;
    logic [5:0]  shot_y_q;
    logic        active_q;
    logic        hit_q;
    logic [2:0]  hit_col_q;
    logic        miss_q;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            draw_req_q    <= 1'b0;
            draw_colour_q <= 1'b0;
            shot_x_q      <= '0;
            shot_y_q      <= '0;
            active_q      <= 1'b0;
            hit_q         <= 1'b0;
            hit_col_q     <= '0;
            miss_q        <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus_io.fire && !bus_io.gameOver) begin
                        shot_x_q      <= bus_io.playerCol;
                        shot_y_q      <= Y_START;
                        draw_req_q    <= 1'b1;
                        draw_colour_q <= 1'b1;
                        active_q      <= 1'b1;
                        state_q       <= StDraw;
                    end
                end
                StDraw: begin
                    if (bus_io.drawDone) begin
                        draw_req_q <= 1'b0;
                        cnt_q      <= STEP_CYCLES - 32'd1;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    // Abort on gameOver still erases the pixel before going idle.
                    if (bus_io.gameOver || cnt_q == '0) begin
                        draw_req_q    <= 1'b1;
                        draw_colour_q <= 1'b0;
                        state_q       <= StErase;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                StErase: begin
                    if (bus_io.drawDone) begin
                        draw_req_q <= 1'b0;
                        if (bus_io.gameOver) begin
                            active_q <= 1'b0;
                            state_q  <= StIdle;
                        end else begin
                            state_q <= StMove;
                        end
                    end
                end
                StMove: begin
                    if (shot_y_q == '0) begin
                        miss_q   <= 1'b1;
                        active_q <= 1'b0;
                        state_q  <= StIdle;
                    end else begin
                        shot_y_q <= shot_y_q - 6'd1;
                        state_q  <= StCheck;
                    end
                end
                StCheck: begin
                    // The hit row is never drawn; alien removal belongs to the alien side.
                    if (shot_y_q == bus_io.alienY && bus_io.alienMask[shot_x_q]) begin
                        hit_q     <= 1'b1;
                        hit_col_q <= shot_x_q;
                        active_q  <= 1'b0;
                        state_q   <= StIdle;
                    end else begin
                        draw_req_q    <= 1'b1;
                        draw_colour_q <= 1'b1;
                        state_q       <= StDraw;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.drawReq    = draw_req_q;
    assign bus_io.drawColour = draw_colour_q;
    assign bus_io.shotX      = shot_x_q;
    assign bus_io.shotY      = shot_y_q;
    assign bus_io.active     = active_q;
    assign bus_io.hit        = hit_q;
    assign bus_io.hitCol     = hit_col_q;
    assign bus_io.miss       = miss_q;

endmodule

// File: tb/tb_shot_rising_ctrl.sv
// Scoreboard bench for shot_rising_ctrl: stimulus pushes expected draw/erase/hit/miss
// transactions, a negedge monitor pops and compares them as the DUT presents them.
module tb_shot_rising_ctrl;

    localparam int unsigned StepCycles = 4;

    typedef struct packed {
        logic [1:0] kind;   // 0 draw/erase, 1 hit, 2 miss
        logic       colour;
        logic [2:0] x;
        logic [5:0] y;
    } txn_t;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   ack_delay = 0;
    txn_t exp_q[$];

    shot_rising_ctrl_if bus ();

    shot_rising_ctrl #(
        .STEP_CYCLES(StepCycles)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // VGA arbiter model: zero-wait (done tied high) or done after ack_delay stall cycles.
    initial begin
        int wcnt = 0;
        bus.drawDone = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_delay == 0) begin
                bus.drawDone = 1'b1;
            end else if (bus.drawReq && !bus.drawDone) begin
                if (wcnt == ack_delay) begin
                    bus.drawDone = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                bus.drawDone = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: pops expected transactions and checks handshake stability.
    initial begin
        logic prev_req = 1'b0;
        logic prev_done = 1'b0;
        logic [9:0] prev_pix = '0;
        txn_t act;
        txn_t exp;
        forever begin
            @(negedge clk);
            if (!Reset) begin
                if (bus.drawReq && bus.drawDone) begin
                    act = '{kind: 2'd0, colour: bus.drawColour, x: bus.shotX, y: bus.shotY};
                    if (exp_q.size() == 0) chk("unexpected draw", 32'(act), 32'hFFFF);
                    else begin
                        exp = exp_q.pop_front();
                        chk("draw txn", 32'(act), 32'(exp));
                    end
                end
                if (bus.hit) begin
                    act = '{kind: 2'd1, colour: 1'b0, x: bus.hitCol, y: 6'd0};
                    if (exp_q.size() == 0) chk("unexpected hit", 32'(act), 32'hFFFF);
                    else begin
                        exp = exp_q.pop_front();
                        chk("hit txn", 32'(act), 32'(exp));
                    end
                end
                if (bus.miss) begin
                    act = '{kind: 2'd2, colour: 1'b0, x: 3'd0, y: 6'd0};
                    if (exp_q.size() == 0) chk("unexpected miss", 32'(act), 32'hFFFF);
                    else begin
                        exp = exp_q.pop_front();
                        chk("miss txn", 32'(act), 32'(exp));
                    end
                end
                if (bus.hit && bus.miss) chk("hit and miss together", 32'd1, 32'd0);
                if (bus.drawReq && prev_req && !prev_done)
                    chk("stall hold", 32'({bus.drawColour, bus.shotX, bus.shotY}), 32'(prev_pix));
            end
            prev_req  = bus.drawReq;
            prev_done = bus.drawDone;
            prev_pix  = {bus.drawColour, bus.shotX, bus.shotY};
        end
    end

    // Draw/erase pairs from Y_START down to last_row, then a hit or miss record.
    task automatic push_flight(input logic [2:0] col, input int last_row, input bit is_hit);
        for (int y = 58; y >= last_row; y--) begin
            exp_q.push_back('{kind: 2'd0, colour: 1'b1, x: col, y: 6'(y)});
            exp_q.push_back('{kind: 2'd0, colour: 1'b0, x: col, y: 6'(y)});
        end
        if (is_hit) exp_q.push_back('{kind: 2'd1, colour: 1'b0, x: col, y: 6'd0});
        else        exp_q.push_back('{kind: 2'd2, colour: 1'b0, x: 3'd0, y: 6'd0});
    endtask

    task automatic launch(input logic [2:0] col);
        @(negedge clk);
        bus.fire = 1'b1;
        bus.playerCol = col;
        @(posedge clk);
        #1 bus.fire = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (bus.active && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("idle timeout", 32'(bus.active), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " drawReq"},    32'(bus.drawReq),    32'd0);
        chk({tag, " drawColour"}, 32'(bus.drawColour), 32'd0);
        chk({tag, " shotX"},      32'(bus.shotX),      32'd0);
        chk({tag, " shotY"},      32'(bus.shotY),      32'd0);
        chk({tag, " active"},     32'(bus.active),     32'd0);
        chk({tag, " hit"},        32'(bus.hit),        32'd0);
        chk({tag, " hitCol"},     32'(bus.hitCol),     32'd0);
        chk({tag, " miss"},       32'(bus.miss),       32'd0);
    endtask

    initial begin
        int n;
        bus.fire = 1'b0;
        bus.playerCol = '0;
        bus.alienY = '0;
        bus.alienMask = '0;
        bus.gameOver = 1'b0;
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Launch latency, first pixel and step period.
        push_flight(3'd3, 0, 1'b0);
        launch(3'd3);
        chk("launch drawReq", 32'(bus.drawReq), 32'd1);
        chk("launch colour", 32'(bus.drawColour), 32'd1);
        chk("launch shotX", 32'(bus.shotX), 32'd3);
        chk("launch shotY", 32'(bus.shotY), 32'd58);
        chk("launch active", 32'(bus.active), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.drawReq && bus.drawColour && bus.shotY == 6'd57) && n < 50);
        chk("step period", 32'(n), 32'(StepCycles + 4));
        wait_idle(2000);

        // Full miss from column 0.
        push_flight(3'd0, 0, 1'b0);
        launch(3'd0);
        wait_idle(2000);

        // Hit on a live alien in column 2 at row 50.
        bus.alienY = 6'd50;
        bus.alienMask = 8'b0000_0100;
        push_flight(3'd2, 51, 1'b1);
        launch(3'd2);
        wait_idle(2000);
        @(negedge clk);
        chk("hitCol hold", 32'(bus.hitCol), 32'd2);

        // Dead column at the alien row passes through.
        bus.alienMask = 8'b1111_1011;
        push_flight(3'd2, 0, 1'b0);
        launch(3'd2);
        wait_idle(2000);

        // Stalled arbiter; fire mid-flight is ignored.
        bus.alienMask = 8'h00;
        ack_delay = 5;
        push_flight(3'd5, 0, 1'b0);
        launch(3'd5);
        repeat (30) @(negedge clk);
        bus.playerCol = 3'd1;
        bus.fire = 1'b1;
        repeat (3) @(negedge clk);
        chk("refire shotX", 32'(bus.shotX), 32'd5);
        bus.fire = 1'b0;
        wait_idle(4000);

        // gameOver in WAIT at row 40: erase then idle.
        ack_delay = 0;
        repeat (2) @(negedge clk);
        push_flight(3'd4, 41, 1'b0);
        void'(exp_q.pop_back());
        exp_q.push_back('{kind: 2'd0, colour: 1'b1, x: 3'd4, y: 6'd40});
        exp_q.push_back('{kind: 2'd0, colour: 1'b0, x: 3'd4, y: 6'd40});
        launch(3'd4);
        n = 0;
        while (!(bus.drawReq && bus.drawColour && bus.shotY == 6'd40) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.gameOver = 1'b1;
        @(negedge clk);
        chk("abort erase req", 32'(bus.drawReq), 32'd1);
        chk("abort erase colour", 32'(bus.drawColour), 32'd0);
        chk("abort erase row", 32'(bus.shotY), 32'd40);
        wait_idle(20);
        bus.fire = 1'b1;
        repeat (3) @(negedge clk);
        chk("gameOver blocks fire", 32'({bus.active, bus.drawReq}), 32'd0);
        bus.fire = 1'b0;
        bus.gameOver = 1'b0;

        // Reset during a stalled erase.
        ack_delay = 5;
        exp_q.push_back('{kind: 2'd0, colour: 1'b1, x: 3'd1, y: 6'd58});
        launch(3'd1);
        n = 0;
        while (!(bus.drawReq && !bus.drawColour) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("erase reached", 32'(bus.drawReq && !bus.drawColour), 32'd1);
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        check_reset_outputs("erase reset");
        ack_delay = 0;
        repeat (5) @(negedge clk);
        chk("queue drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shot_rising_ctrl.md
Name: shot_rising_ctrl

Overview:
- Controls the player's shot as it travels upward. It is the mirror of the alien-fall path: aliens step down, and the shot steps up.
- On a fire request it latches the player column, then repeatedly draws, waits one step period, erases and moves the shot up one row. At each new row it checks for a collision with the alien row.
- Sits between player input, the alien-fall counter (alien row and alive mask) and the VGA draw arbiter, which it drives through a request/done handshake.

Parameters:
- CLOCK_FREQUENCY, 50000000, system clock in Hz.
- STEP_CYCLES, CLOCK_FREQUENCY/3, clock cycles per one-row upward step (3 rows/s). Must be ≥1; benches use 4.
- Y_START, 6'd58, row at which a new shot spawns, just above the home base.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- fire  in  1  level request to launch a shot. Sampled only in IDLE.
- playerCol  in  3  player column index, latched on launch.
- alienY  in  6  current alien row from the alien-fall display counter.
- alienMask  in  8  alive alien per column; bit i = column i.
- gameOver  in  1  aborts the shot and blocks new launches.
- drawDone  in  1  one-cycle ack from the VGA arbiter for the current request.
- drawReq  out  1  level request to VGA; held until drawDone.
- drawColour  out  1  1 = draw shot pixel, 0 = erase (background).
- shotX  out  3  column of the shot being drawn or erased.
- shotY  out  6  row of the shot being drawn or erased.
- active  out  1  high whenever state ≠ IDLE.
- hit  out  1  one-cycle pulse on collision.
- hitCol  out  3  column hit; valid when hit=1, holds its last value otherwise.
- miss  out  1  one-cycle pulse when the shot leaves the top of the screen (row 0 exceeded).

Behaviour:
- Reset values: state IDLE, drawReq 0, drawColour 0, shotX 0, shotY 0, active 0, hit 0, hitCol 0, miss 0, step counter 0.
- Reset in any state, including mid-handshake, returns to IDLE next edge. drawReq drops with no erase issued; the VGA side is cleared by the top-level reset.
- IDLE:
  - If fire=1 and gameOver=0: shotX←playerCol, shotY←Y_START, go to DRAW.
  - fire while not in IDLE is ignored; there is no queueing.
- DRAW:
  - drawReq=1, drawColour=1, shotX/shotY stable.
  - On drawDone: drawReq←0, load counter with STEP_CYCLES−1, go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - If gameOver=1, go to ERASE immediately.
  - At counter==0, go to ERASE. The shot is therefore visible for exactly STEP_CYCLES cycles after drawDone.
- ERASE:
  - drawReq=1, drawColour=0, same coordinates.
  - On drawDone: if gameOver=1, go to IDLE; else go to MOVE.
- MOVE (1 cycle):
  - If shotY==0: miss pulse, go to IDLE.
  - Else shotY←shotY−1, go to CHECK.
- CHECK (1 cycle):
  - If shotY==alienY and alienMask[shotX]==1: hit pulse, hitCol←shotX, go to IDLE. The hit row is not drawn; the alien controller owns removal.
  - Else go to DRAW.
- gameOver in DRAW: finish the handshake, enter WAIT, then exit to ERASE on the next cycle. The shot pixel is always erased before IDLE.
- drawDone received outside DRAW/ERASE is ignored.
- drawDone on the same cycle drawReq first rises is accepted (zero-wait arbiter).
- Arithmetic:
  - shotY is unsigned 6-bit and never decrements below 0; wrap is prevented by the MOVE check.
  - Counter is 32-bit.
- Launch-to-first-drawReq latency: 1 cycle.
- Per step with zero-wait VGA: DRAW 1 + WAIT STEP_CYCLES + ERASE 1 + MOVE 1 + CHECK 1 cycles.
- hit and miss are mutually exclusive and never asserted in the same cycle as drawReq rising.

Test Plan:
- Launch: Reset, fire=1, playerCol=3, drawDone tied 1 → next cycle drawReq=1, drawColour=1, shotX=3, shotY=58. After erase, the next draw is at shotY=57; the step period is STEP_CYCLES+4=8 cycles.
- Miss: alienMask=0, STEP_CYCLES=4, fire at playerCol=0 → 59 draw/erase pairs, rows 58 down to 0. After the erase of row 0, miss pulses once, then IDLE with active=0. No hit.
- Hit: alienY=50, alienMask=8'b0000_0100, playerCol=2 → draws rows 58..51. Hit pulses when shotY=50 with hitCol=2. No draw at row 50; IDLE next cycle.
- Dead column passes through: alienY=50, alienMask=8'b1111_1011, playerCol=2 → no hit at row 50, draw at row 50 issued, continues to miss.
- Handshake stall and fire-ignore: drawDone delayed 5 cycles → drawReq and coordinates held stable for 5 cycles. Re-asserting fire mid-flight does not change shotX/shotY.
- Abort and reset:
  - gameOver asserted in WAIT at row 40 → erase at row 40 with drawColour=0, then IDLE. fire with gameOver=1 is ignored.
  - Separately, Reset asserted in ERASE → all outputs at reset values next cycle.
